// File: rtl/avalon_sram_responder_if.sv
// Avalon-MM slave-side bus bundle for the SRAM responder.
interface avalon_sram_responder_if;
  logic [19:0] avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [15:0] avs_writedata;
  logic [1:0]  avs_byteenable;
  logic [15:0] avs_readdata;
  logic        avs_waitrequest;

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
    output avs_readdata, avs_waitrequest
  );

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
    input  avs_readdata, avs_waitrequest
  );
endinterface

// File: rtl/avalon_sram_responder.sv
// Avalon-MM responder driving a 1M x 16 asynchronous SRAM with programmable
// read/write wait states and a post-read bus turnaround. One transfer at a time.
module avalon_sram_responder #(
  parameter int unsigned READ_WAIT  = 2,
  parameter int unsigned WRITE_WAIT = 2,
  parameter int unsigned TURNAROUND = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  avalon_sram_responder_if.slave         avs,
  output logic [19:0]                    SRAM_ADDR,
  inout  wire  [15:0]                    SRAM_DQ,
  output logic                           SRAM_CE_N,
  output logic                           SRAM_OE_N,
  output logic                           SRAM_WE_N,
  output logic                           SRAM_LB_N,
  output logic                           SRAM_UB_N
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] RD_LD   = CNT_W'(READ_WAIT - 1);
  localparam logic [CNT_W-1:0] WR_LD   = CNT_W'(WRITE_WAIT - 1);
  localparam logic [CNT_W-1:0] TURN_LD = (TURNAROUND > 0) ? CNT_W'(TURNAROUND - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_RD_ACK, S_TURN, S_WR, S_WR_ACK
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [19:0]      r_addr;
  logic [15:0]      r_dq_out;
  logic             r_dq_oe;
  logic [15:0]      r_readdata;
  logic             r_waitrequest;
  logic             r_ce_n;
  logic             r_oe_n;
  logic             r_we_n;
  logic             r_lb_n;
  logic             r_ub_n;

  // Transfer sequencer; every pin value is registered on the transition into its state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_addr        <= '0;
      r_dq_out      <= '0;
      r_dq_oe       <= 1'b0;
      r_readdata    <= '0;
      r_waitrequest <= 1'b1;
      r_ce_n        <= 1'b1;
      r_oe_n        <= 1'b1;
      r_we_n        <= 1'b1;
      r_lb_n        <= 1'b1;
      r_ub_n        <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (avs.avs_write) begin
            r_state  <= S_WR;
            r_cnt    <= WR_LD;
            r_addr   <= avs.avs_address;
            r_dq_out <= avs.avs_writedata;
            r_dq_oe  <= 1'b1;
            r_ce_n   <= 1'b0;
            r_we_n   <= 1'b0;
            r_oe_n   <= 1'b1;
            r_lb_n   <= ~avs.avs_byteenable[0];
            r_ub_n   <= ~avs.avs_byteenable[1];
          end else if (avs.avs_read) begin
            r_state  <= S_RD;
            r_cnt    <= RD_LD;
            r_addr   <= avs.avs_address;
            r_ce_n   <= 1'b0;
            r_oe_n   <= 1'b0;
            r_lb_n   <= ~avs.avs_byteenable[0];
            r_ub_n   <= ~avs.avs_byteenable[1];
          end
        end
        S_RD: begin
          if (r_cnt == '0) begin
            r_state       <= S_RD_ACK;
            r_readdata    <= SRAM_DQ;
            r_waitrequest <= 1'b0;
            r_ce_n        <= 1'b1;
            r_oe_n        <= 1'b1;
            r_lb_n        <= 1'b1;
            r_ub_n        <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_RD_ACK: begin
          r_waitrequest <= 1'b1;
          if (TURNAROUND > 0) begin
            r_state <= S_TURN;
            r_cnt   <= TURN_LD;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_TURN: begin
          if (r_cnt == '0) r_state <= S_IDLE;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        S_WR: begin
          if (r_cnt == '0) begin
            // WE_N rises first; CE_N and data stay for hold time through the ack cycle.
            r_state       <= S_WR_ACK;
            r_we_n        <= 1'b1;
            r_waitrequest <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_WR_ACK: begin
          r_state       <= S_IDLE;
          r_waitrequest <= 1'b1;
          r_dq_oe       <= 1'b0;
          r_ce_n        <= 1'b1;
          r_lb_n        <= 1'b1;
          r_ub_n        <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign SRAM_DQ             = r_dq_oe ? r_dq_out : 16'hzzzz;
  assign SRAM_ADDR           = r_addr;
  assign SRAM_CE_N           = r_ce_n;
  assign SRAM_OE_N           = r_oe_n;
  assign SRAM_WE_N           = r_we_n;
  assign SRAM_LB_N           = r_lb_n;
  assign SRAM_UB_N           = r_ub_n;
  assign avs.avs_readdata    = r_readdata;
  assign avs.avs_waitrequest = r_waitrequest;

endmodule

// File: tb/tb_avalon_sram_responder.sv
// Bench for avalon_sram_responder: vector table through a scoreboard plus
// hand-written reset, back-to-back, read/write collision and READ_WAIT=1 cases.
module tb_avalon_sram_responder;

  localparam int RW = 2;
  localparam int WW = 2;

  logic clk = 1'b0;
  logic reset;
  always #10 clk = ~clk;

  avalon_sram_responder_if bus1();
  avalon_sram_responder_if bus2();

  wire  [15:0] sram_dq;
  logic [19:0] sram_addr;
  logic        ce_n, oe_n, we_n, lb_n, ub_n;

  wire  [15:0] dq2;
  logic [19:0] addr2;
  logic        ce2, oe2, we2, lb2, ub2;

  avalon_sram_responder #(.READ_WAIT(RW), .WRITE_WAIT(WW), .TURNAROUND(1)) dut (
    .clk(clk), .reset(reset), .avs(bus1.slave),
    .SRAM_ADDR(sram_addr), .SRAM_DQ(sram_dq),
    .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n), .SRAM_WE_N(we_n),
    .SRAM_LB_N(lb_n), .SRAM_UB_N(ub_n)
  );

  avalon_sram_responder #(.READ_WAIT(1), .WRITE_WAIT(2), .TURNAROUND(0)) dut2 (
    .clk(clk), .reset(reset), .avs(bus2.slave),
    .SRAM_ADDR(addr2), .SRAM_DQ(dq2),
    .SRAM_CE_N(ce2), .SRAM_OE_N(oe2), .SRAM_WE_N(we2),
    .SRAM_LB_N(lb2), .SRAM_UB_N(ub2)
  );

  // SRAM model: byte-lane writes commit on every clock edge with WE_N low.
  logic [15:0] mem [256];
  assign sram_dq = (!ce_n && !oe_n && we_n) ? mem[sram_addr[7:0]] : 16'hzzzz;
  always @(posedge clk) begin
    if (!ce_n && !we_n) begin
      if (!lb_n) mem[sram_addr[7:0]][7:0]  <= sram_dq[7:0];
      if (!ub_n) mem[sram_addr[7:0]][15:8] <= sram_dq[15:8];
    end
  end

  // Second device returns a fixed word whenever it is read.
  assign dq2 = (!ce2 && !oe2 && we2) ? 16'h7E57 : 16'hzzzz;

  // Flags the SRAM driving the bus while a write strobe is active.
  bit contention = 1'b0;
  always @(negedge clk) if (!oe_n && !we_n) contention <= 1'b1;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_q[$];

  typedef struct {
    bit          wr;
    logic [19:0] addr;
    logic [15:0] data;
    logic [1:0]  be;
    logic [15:0] exp_rd;
  } vec_t;
  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Runs one transfer on dut starting at a negedge in IDLE; ends at the ack
  // negedge, or, with post=1, at the negedge of the following IDLE cycle.
  task automatic xfer(input bit wr, input bit rd, input logic [19:0] a,
                      input logic [15:0] d, input logic [1:0] be,
                      input logic [15:0] exp_rd, input int exp_lat,
                      input bit post, input string tag);
    int cyc = 0, we_lo = 0, oe_lo = 0;
    bit lane_ok = 1'b1, dq_ok = 1'b1, rel_ok = 1'b1, done = 1'b0;
    logic [15:0] e;
    bus1.avs_address    = a;
    bus1.avs_writedata  = d;
    bus1.avs_byteenable = be;
    bus1.avs_write      = wr;
    bus1.avs_read       = rd;
    if (rd && !wr) exp_q.push_back(exp_rd);
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (!we_n) we_lo++;
      if (!oe_n) oe_lo++;
      if (!ce_n && ({ub_n, lb_n} != ~be)) lane_ok = 1'b0;
      if (wr && !ce_n && sram_dq != d) dq_ok = 1'b0;
      if (ce_n && sram_dq != 16'h0) rel_ok = 1'b0;
      if (!bus1.avs_waitrequest) done = 1'b1;
    end
    bus1.avs_write = 1'b0;
    bus1.avs_read  = 1'b0;
    chk({tag, "_ack_seen"}, 32'(done), 32'd1);
    chk({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
    chk({tag, "_we_low_cycles"}, 32'(we_lo), wr ? 32'(WW) : 32'd0);
    chk({tag, "_oe_low_cycles"}, 32'(oe_lo), wr ? 32'd0 : 32'(RW));
    chk({tag, "_byte_lanes"}, 32'(lane_ok), 32'd1);
    chk({tag, "_dq_released"}, 32'(rel_ok), 32'd1);
    chk({tag, "_sram_addr"}, 32'(sram_addr), 32'(a));
    if (wr) chk({tag, "_dq_write_data"}, 32'(dq_ok), 32'd1);
    if (rd && !wr && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_readdata"}, 32'(bus1.avs_readdata), 32'(e));
    end
    if (post) begin
      @(negedge clk);
      chk({tag, "_post_wait"}, 32'(bus1.avs_waitrequest), 32'd1);
      chk({tag, "_post_ctrl"}, 32'({ce_n, oe_n, we_n}), 32'b111);
      chk({tag, "_post_dq"}, 32'(sram_dq), 32'd0);
      if (!wr) begin
        chk({tag, "_rd_hold"}, 32'(bus1.avs_readdata), 32'(exp_rd));
        @(negedge clk);
        chk({tag, "_idle_wait"}, 32'(bus1.avs_waitrequest), 32'd1);
      end
    end
  endtask

  initial begin
    int c2, oe_c2;
    bit done2;

    vecs[0] = '{1'b1, 20'h12345, 16'hA5A5, 2'b11, 16'h0000};
    vecs[1] = '{1'b0, 20'h12345, 16'h0000, 2'b11, 16'hA5A5};
    vecs[2] = '{1'b1, 20'h00010, 16'h1234, 2'b11, 16'h0000};
    vecs[3] = '{1'b1, 20'h00010, 16'h00FF, 2'b01, 16'h0000};
    vecs[4] = '{1'b0, 20'h00010, 16'h0000, 2'b11, 16'h12FF};
    vecs[5] = '{1'b1, 20'h00020, 16'hBEEF, 2'b11, 16'h0000};
    vecs[6] = '{1'b1, 20'h00020, 16'hC0DE, 2'b10, 16'h0000};
    vecs[7] = '{1'b0, 20'h00020, 16'h0000, 2'b11, 16'hC0EF};
    vecs[8] = '{1'b1, 20'h00030, 16'h5555, 2'b11, 16'h0000};
    vecs[9] = '{1'b1, 20'h00030, 16'hFFFF, 2'b00, 16'h0000};

    reset = 1'b1;
    bus1.avs_address = '0; bus1.avs_read = 1'b0; bus1.avs_write = 1'b0;
    bus1.avs_writedata = '0; bus1.avs_byteenable = '0;
    bus2.avs_address = '0; bus2.avs_read = 1'b0; bus2.avs_write = 1'b0;
    bus2.avs_writedata = '0; bus2.avs_byteenable = '0;
    repeat (3) @(negedge clk);
    chk("reset_waitrequest", 32'(bus1.avs_waitrequest), 32'd1);
    chk("reset_readdata", 32'(bus1.avs_readdata), 32'd0);
    chk("reset_sram_addr", 32'(sram_addr), 32'd0);
    chk("reset_ctrl", 32'({ce_n, oe_n, we_n, lb_n, ub_n}), 32'b11111);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      xfer(vecs[i].wr, !vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].be,
           vecs[i].exp_rd, vecs[i].wr ? WW + 1 : RW + 1, 1'b1, $sformatf("v%0d", i));
    end
    // Byte-enable 00 write must leave the word intact.
    xfer(1'b0, 1'b1, 20'h00030, 16'h0, 2'b11, 16'h5555, RW + 1, 1'b1, "be00_readback");

    // Read then write presented right after the read ack: TURN and IDLE precede WE_N.
    xfer(1'b0, 1'b1, 20'h12345, 16'h0, 2'b11, 16'hA5A5, RW + 1, 1'b0, "b2b_rd");
    xfer(1'b1, 1'b0, 20'h00050, 16'h3C3C, 2'b11, 16'h0, WW + 3, 1'b1, "b2b_wr");
    xfer(1'b0, 1'b1, 20'h00050, 16'h0, 2'b11, 16'h3C3C, RW + 1, 1'b1, "b2b_readback");

    // Reset during the second WR cycle abandons the write.
    bus1.avs_address = 20'h12345; bus1.avs_writedata = 16'h0F0F;
    bus1.avs_byteenable = 2'b11; bus1.avs_write = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid_wr_we_low", 32'(we_n), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_wr_ctrl", 32'({ce_n, oe_n, we_n, lb_n, ub_n}), 32'b11111);
    chk("rst_mid_wr_wait", 32'(bus1.avs_waitrequest), 32'd1);
    chk("rst_mid_wr_dq", 32'(sram_dq), 32'd0);
    chk("rst_mid_wr_readdata", 32'(bus1.avs_readdata), 32'd0);
    bus1.avs_write = 1'b0;
    reset = 1'b0;
    // The model committed the whole word on the first WE_N-low edge.
    xfer(1'b0, 1'b1, 20'h12345, 16'h0, 2'b11, 16'h0F0F, RW + 1, 1'b1, "rst_readback");

    // Read and write together: write wins.
    xfer(1'b1, 1'b1, 20'h00040, 16'h6666, 2'b11, 16'h0, WW + 1, 1'b1, "rw_both");
    xfer(1'b0, 1'b1, 20'h00040, 16'h0, 2'b11, 16'h6666, RW + 1, 1'b1, "rw_readback");

    // READ_WAIT=1 device acks a read on cycle 2.
    bus2.avs_address = 20'h00005; bus2.avs_byteenable = 2'b11; bus2.avs_read = 1'b1;
    c2 = 0; oe_c2 = 0; done2 = 1'b0;
    while (!done2 && c2 < 20) begin
      @(negedge clk);
      c2++;
      if (!oe2) oe_c2++;
      if (!bus2.avs_waitrequest) done2 = 1'b1;
    end
    bus2.avs_read = 1'b0;
    chk("rw1_latency", 32'(c2), 32'd2);
    chk("rw1_oe_low_cycles", 32'(oe_c2), 32'd1);
    chk("rw1_readdata", 32'(bus2.avs_readdata), 32'h7E57);

    chk("no_contention", 32'(contention), 32'd0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
